// File: rtl/left_shift_unit.sv
// Multi-cycle 32-bit logical left shifter: one fixed 16/8/4/2/1 stage per clock, start/ready handshake.
// Optional signed-overflow flag enabled by defining LSHIFT_OVF_EN.
module left_shift_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
`ifdef LSHIFT_OVF_EN
  ,
  output logic        overflow
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] work;
  logic [4:0]  amt;
  logic [4:0]  stage_width;
  logic        stage_on;
  logic [31:0] stage_out;

  // Stage k shifts by 16>>k when the matching shamt bit (MSB first) is set.
  always_comb begin
    stage_width = 5'd16 >> cnt;
    stage_on    = 1'b0;
    case (cnt)
      3'd0:    stage_on = amt[4];
      3'd1:    stage_on = amt[3];
      3'd2:    stage_on = amt[2];
      3'd3:    stage_on = amt[1];
      3'd4:    stage_on = amt[0];
      default: stage_on = 1'b0;
    endcase
    stage_out = stage_on ? (work << stage_width) : work;
  end

`ifdef LSHIFT_OVF_EN
  logic        ovf_acc;
  logic [31:0] top_bits;
  logic        stage_ovf;

  // The top s+1 bits must all match the sign, otherwise the s-bit shift loses magnitude.
  always_comb begin
    top_bits  = 32'($signed(work) >>> (5'd31 - stage_width));
    stage_ovf = stage_on && !((top_bits == 32'h0) || (top_bits == 32'hFFFF_FFFF));
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      work           <= 32'h0;
      amt            <= 5'd0;
      data_result    <= 32'h0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef LSHIFT_OVF_EN
      ovf_acc        <= 1'b0;
      overflow       <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      if (state == SHIFT) begin
        work <= stage_out;
`ifdef LSHIFT_OVF_EN
        ovf_acc <= ovf_acc | stage_ovf;
`endif
        if (cnt == 3'd4) begin
          data_result    <= stage_out;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
          state          <= DONE;
`ifdef LSHIFT_OVF_EN
          overflow       <= ovf_acc | stage_ovf;
`endif
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else if (ctrl_shift) begin
        // Idle or done: accept a new op, which also allows back-to-back issue from DONE.
        work  <= data_operandA;
        amt   <= shamt;
        cnt   <= 3'd0;
        busy  <= 1'b1;
        state <= SHIFT;
`ifdef LSHIFT_OVF_EN
        ovf_acc <= 1'b0;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
